// File: rtl/wbaq_pkg.sv
// rtl/wbaq_pkg.sv - shared types, constants and line-set helper for the write-back address queue
// Purpose: default depth/widths, memory size encodings, line offset, entry struct,
//          and the helper that computes the last 16B line touched by an access.
// Ports: none (package).
package wbaq_pkg;

    localparam int WBAQ_DEPTH  = 8;
    localparam int WBAQ_ADDR_W = 32;
    localparam int WBAQ_DATA_W = 64;
    localparam int LINE_OFS    = 4;
    localparam int LINE_W      = WBAQ_ADDR_W - LINE_OFS;

    localparam logic [1:0] MEMSZ_1B = 2'b00;
    localparam logic [1:0] MEMSZ_2B = 2'b01;
    localparam logic [1:0] MEMSZ_4B = 2'b10;
    localparam logic [1:0] MEMSZ_8B = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [WBAQ_ADDR_W-1:0] addr;
        logic [WBAQ_DATA_W-1:0] data;
        logic [1:0]             size;
    } wbaq_entry_t;

    // Line index of the last byte of an access; an 8B access can straddle two lines.
    function automatic logic [LINE_W-1:0] line_last(input logic [WBAQ_ADDR_W-1:0] addr,
                                                    input logic [1:0]             size);
        logic [3:0]             span;
        logic [WBAQ_ADDR_W-1:0] end_addr;
        span     = (4'd1 << size) - 4'd1;
        end_addr = addr + {{(WBAQ_ADDR_W-4){1'b0}}, span};
        return end_addr[WBAQ_ADDR_W-1:LINE_OFS];
    endfunction

endpackage

// File: rtl/wbaq_store_queue_if.sv
// rtl/wbaq_store_queue_if.sv - store queue bus: enqueue, dequeue, conflict check and status
// Purpose: groups the writeback-side, D-cache-side and memory-read-side signals.
// Ports: enq_valid/enq_addr/enq_data/enq_size (writeback), full, deq_valid/deq_ready/
//        deq_addr/deq_data/deq_size (D-cache), chk_addr/chk_size/chk_conflict (load check),
//        overflow, count. master = queue user, slave = queue.
interface wbaq_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              enq_valid;
    logic [ADDR_W-1:0] enq_addr;
    logic [DATA_W-1:0] enq_data;
    logic [1:0]        enq_size;
    logic              full;
    logic              deq_valid;
    logic              deq_ready;
    logic [ADDR_W-1:0] deq_addr;
    logic [DATA_W-1:0] deq_data;
    logic [1:0]        deq_size;
    logic [ADDR_W-1:0] chk_addr;
    logic [1:0]        chk_size;
    logic              chk_conflict;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output enq_valid, enq_addr, enq_data, enq_size, deq_ready, chk_addr, chk_size,
        input  full, deq_valid, deq_addr, deq_data, deq_size, chk_conflict, overflow, count
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_size, deq_ready, chk_addr, chk_size,
        output full, deq_valid, deq_addr, deq_data, deq_size, chk_conflict, overflow, count
    );

endinterface

// File: rtl/wbaq_slot.sv
// rtl/wbaq_slot.sv - one store queue entry with write, clear-on-dequeue and line-set compare
// Purpose: holds a committed store and flags overlap of its 16B line set with a load's.
// Ports: clk, rst (async active-low), wr_en/wr_entry (load entry), clr (drop valid on
//        dequeue), chk_addr/chk_size (load), entry (stored contents), conflict.
module wbaq_slot
    import wbaq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   clr,
    input  wbaq_entry_t            wr_entry,
    input  logic [WBAQ_ADDR_W-1:0] chk_addr,
    input  logic [1:0]             chk_size,
    output wbaq_entry_t            entry,
    output logic                   conflict
);

    wbaq_entry_t       entry_q, entry_d;
    logic [LINE_W-1:0] s_first, s_last, c_first, c_last;

    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d.valid = 1'b0;
        end
        if (wr_en) begin
            entry_d = wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    // Each access touches at most two lines, so four compares cover every overlap.
    always_comb begin
        s_first  = entry_q.addr[WBAQ_ADDR_W-1:LINE_OFS];
        s_last   = line_last(entry_q.addr, entry_q.size);
        c_first  = chk_addr[WBAQ_ADDR_W-1:LINE_OFS];
        c_last   = line_last(chk_addr, chk_size);
        conflict = entry_q.valid &
                   ((s_first == c_first) | (s_first == c_last) |
                    (s_last  == c_first) | (s_last  == c_last));
    end

    assign entry = entry_q;

endmodule

// File: rtl/wbaq_store_queue.sv
// rtl/wbaq_store_queue.sv - in-order write-back address queue between writeback and D-cache
// Purpose: buffers committed stores, drains them in order, stalls writeback via full,
//          and reports load/store 16B line conflicts. Macro WBAQ_BYPASS_EN enables an
//          empty-queue same-cycle bypass from enqueue to dequeue.
// Ports: clk, rst (async active-low), bus (wbaq_if.slave: enq_*, full, deq_*, chk_*,
//        overflow, count).
module wbaq_store_queue
    import wbaq_pkg::*;
#(
    parameter int DEPTH  = WBAQ_DEPTH,
    parameter int ADDR_W = WBAQ_ADDR_W,
    parameter int DATA_W = WBAQ_DATA_W
) (
    input logic   clk,
    input logic   rst,
    wbaq_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    wbaq_entry_t      slot_entry [DEPTH];
    logic [DEPTH-1:0] slot_wr, slot_clr, slot_conflict;
    wbaq_entry_t      enq_entry, head_entry;
    logic             full, empty, bypass, enq_wr, deq_fire;

    // full is registered occupancy only; a same-cycle dequeue does not free a slot early.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        enq_entry.valid = 1'b1;
        enq_entry.addr  = WBAQ_ADDR_W'(bus.enq_addr);
        enq_entry.data  = WBAQ_DATA_W'(bus.enq_data);
        enq_entry.size  = bus.enq_size;
        head_entry      = slot_entry[head_q];

`ifdef WBAQ_BYPASS_EN
        bypass = empty & bus.enq_valid & bus.deq_ready;
`else
        bypass = 1'b0;
`endif

        enq_wr     = bus.enq_valid & ~full & ~bypass;
        deq_fire   = head_entry.valid & bus.deq_ready;
        head_d     = head_q + PTR_W'(deq_fire);
        tail_d     = tail_q + PTR_W'(enq_wr);
        count_d    = count_q + CNT_W'(enq_wr) - CNT_W'(deq_fire);
        overflow_d = overflow_q | (bus.enq_valid & full);

        slot_wr  = '0;
        slot_clr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_wr[i]  = enq_wr   && (tail_q == PTR_W'(i));
            slot_clr[i] = deq_fire && (head_q == PTR_W'(i));
        end

        bus.deq_valid    = head_entry.valid | bypass;
        bus.deq_addr     = bypass ? bus.enq_addr : ADDR_W'(head_entry.addr);
        bus.deq_data     = bypass ? bus.enq_data : DATA_W'(head_entry.data);
        bus.deq_size     = bypass ? bus.enq_size : head_entry.size;
        bus.full         = full;
        bus.count        = count_q;
        bus.overflow     = overflow_q;
        bus.chk_conflict = |slot_conflict;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        wbaq_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (slot_wr[g]),
            .clr      (slot_clr[g]),
            .wr_entry (enq_entry),
            .chk_addr (WBAQ_ADDR_W'(bus.chk_addr)),
            .chk_size (bus.chk_size),
            .entry    (slot_entry[g]),
            .conflict (slot_conflict[g])
        );
    end

endmodule
